// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared select encoding and helpers for the program-counter unit
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_CALL,
        SEL_RET,
        SEL_RST
    } pc_sel_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clears the byte-offset bits below one instruction step.
    function automatic logic [63:0] align_mask(input int step);
        return ~(64'(step) - 64'd1);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with saturating count
module ras_stack
    import pc_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            pcrst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            ovf_pulse,
    output logic            unf_pulse
);

    localparam int PW = clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   top_ptr;
    logic [PW-1:0]   up_ptr;
    logic [PW-1:0]   down_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(RAS_DEPTH));
    assign top      = mem[top_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && !pop;
    assign ovf_pulse = do_push && full;
    assign unf_pulse = pop && empty;

    // Explicit wrap so non-power-of-two depths stay circular.
    assign up_ptr   = (top_ptr == PW'(RAS_DEPTH - 1)) ? '0 : top_ptr + PW'(1);
    assign down_ptr = (top_ptr == '0) ? PW'(RAS_DEPTH - 1) : top_ptr - PW'(1);

    always_ff @(posedge clk) begin
        if (pcrst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (do_pop) begin
            top_ptr <= down_ptr;
            count   <= count - CW'(1);
        end else if (do_push) begin
            top_ptr <= up_ptr;
            if (!full) begin
                count <= count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!pcrst && do_push) begin
            mem[up_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch-address generator with branch/jump/call/ret and return-address stack
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            pcrst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic            call,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next,
    output logic            valid,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam logic [PC_W-1:0] MASK   = PC_W'(align_mask(STEP));
    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] ras_top;
    logic            push;
    logic            pop;
    logic            ovf_pulse;
    logic            unf_pulse;

    assign pc_seq = pc + STEP_V;

    // The first cycle out of reset fetches RESET_VEC itself, so redirects wait until valid.
    always_comb begin
        sel = SEL_SEQ;
        if (pcrst) begin
            sel = SEL_RST;
        end else if (stall || !valid) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            sel = ras_empty ? SEL_SEQ : SEL_RET;
        end else if (call) begin
            sel = SEL_CALL;
        end else if (jmp) begin
            sel = SEL_JMP;
        end else if (br_taken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_RST:  pc_next = RESET_VEC;
            SEL_HOLD: pc_next = pc;
            SEL_SEQ:  pc_next = pc_seq;
            SEL_BR:   pc_next = br_target & MASK;
            SEL_JMP:  pc_next = jmp_target & MASK;
            SEL_CALL: pc_next = jmp_target & MASK;
            SEL_RET:  pc_next = ras_top & MASK;
            default:  pc_next = pc;
        endcase
    end

    assign push = (sel == SEL_CALL);
    assign pop  = !pcrst && !stall && valid && ret;

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .pcrst     (pcrst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf_pulse (ovf_pulse),
        .unf_pulse (unf_pulse)
    );

    always_ff @(posedge clk) begin
        if (pcrst) begin
            pc            <= RESET_VEC;
            valid         <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            valid         <= 1'b1;
            ras_overflow  <= ras_overflow | ovf_pulse;
            ras_underflow <= ras_underflow | unf_pulse;
        end
    end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - randomized and directed bench for pc_unit_ras against a queue-based model
module tb_pc_unit_ras;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h100;
    localparam logic [31:0] RV_W  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        pcrst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp = 1'b0;
    logic        call = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        ret = 1'b0;

    logic [31:0] pc, pc_next, w_pc, w_pc_next;
    logic        valid, ras_empty, ras_full, ras_overflow, ras_underflow;
    logic        w_valid, w_empty, w_full, w_ovf, w_unf;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc = RV;
    logic        m_valid = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [31:0] m_stack [$];

    always #5 clk = ~clk;

    pc_unit_ras #(.PC_W(32), .RESET_VEC(RV), .STEP(4), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .pcrst(pcrst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .call(call), .jmp_target(jmp_target), .ret(ret),
        .pc(pc), .pc_next(pc_next), .valid(valid), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    pc_unit_ras #(.PC_W(32), .RESET_VEC(RV_W), .STEP(4), .RAS_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .pcrst(pcrst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .call(call), .jmp_target(jmp_target), .ret(ret),
        .pc(w_pc), .pc_next(w_pc_next), .valid(w_valid), .ras_empty(w_empty), .ras_full(w_full),
        .ras_overflow(w_ovf), .ras_underflow(w_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic c, input logic [31:0] jt, input logic rt);
        pcrst = r; stall = s; br_taken = b; br_target = bt;
        jmp = j; call = c; jmp_target = jt; ret = rt;
    endtask

    // One clock: model the spec's priority rules, check pc_next, clock, check all state.
    task automatic cycle();
        logic [31:0] n_pc;
        logic        n_valid, n_ovf, n_unf;
        logic [31:0] n_stack [$];
        n_pc = m_pc; n_valid = m_valid; n_ovf = m_ovf; n_unf = m_unf; n_stack = m_stack;
        if (pcrst) begin
            n_pc = RV; n_valid = 1'b0; n_ovf = 1'b0; n_unf = 1'b0; n_stack = {};
        end else if (!m_valid) begin
            n_valid = 1'b1;
        end else if (stall) begin
            n_pc = m_pc;
        end else if (ret) begin
            if (n_stack.size() > 0) n_pc = n_stack.pop_back() & 32'hFFFF_FFFC;
            else begin n_pc = m_pc + 32'd4; n_unf = 1'b1; end
        end else if (call) begin
            n_stack.push_back(m_pc + 32'd4);
            if (n_stack.size() > DEPTH) begin void'(n_stack.pop_front()); n_ovf = 1'b1; end
            n_pc = jmp_target & 32'hFFFF_FFFC;
        end else if (jmp) begin
            n_pc = jmp_target & 32'hFFFF_FFFC;
        end else if (br_taken) begin
            n_pc = br_target & 32'hFFFF_FFFC;
        end else begin
            n_pc = m_pc + 32'd4;
        end
        #1;
        check("pc_next", pc_next, n_pc);
        @(posedge clk);
        #1;
        m_pc = n_pc; m_valid = n_valid; m_ovf = n_ovf; m_unf = n_unf; m_stack = n_stack;
        check("pc", pc, m_pc);
        check("valid", 32'(valid), 32'(m_valid));
        check("ras_empty", 32'(ras_empty), 32'(m_stack.size() == 0));
        check("ras_full", 32'(ras_full), 32'(m_stack.size() == DEPTH));
        check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
        check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    initial begin
        // Reset held three cycles, wrap instance watched alongside
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 1, 32'h40, 0);
            cycle();
            check("rst_pc", pc, 32'h100);
            check("rst_valid", 32'(valid), 0);
            check("wrap_rst_pc", w_pc, RV_W);
        end
        idle(1);
        check("first_pc", pc, 32'h100);
        check("first_valid", 32'(valid), 1);
        check("wrap_first_pc", w_pc, RV_W);
        idle(1);
        check("seq_pc", pc, 32'h104);
        check("wrap_pc_wraps", w_pc, 32'h0);
        idle(1);
        check("seq_pc2", pc, 32'h108);

        // Stall holds despite a taken branch, then branch, then misaligned branch
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 32'h200, 0, 0, 0, 0);
            cycle();
            check("stall_hold", pc, 32'h108);
        end
        drive(0, 0, 1, 32'h200, 0, 0, 0, 0); cycle();
        check("branch", pc, 32'h200);
        drive(0, 0, 1, 32'h203, 0, 0, 0, 0); cycle();
        check("branch_align", pc, 32'h200);

        // Call/ret pair
        drive(0, 0, 0, 0, 0, 1, 32'h400, 0); cycle();
        check("call_pc", pc, 32'h400);
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        check("ret_pc", pc, 32'h204);

        // Five nested calls, four LIFO rets, one underflowing ret
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1, 32'h1000 * (i + 1), 0);
            cycle();
        end
        check("ovf_set", 32'(ras_overflow), 1);
        check("full_set", 32'(ras_full), 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            cycle();
            check("lifo_ret", pc, 32'h1000 * (4 - i) + 32'h4);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        check("unf_ret_pc", pc, 32'h1008);
        check("unf_set", 32'(ras_underflow), 1);
        idle(3);
        check("ovf_sticky", 32'(ras_overflow), 1);

        // Priority: all redirects with one entry 0x500
        drive(0, 0, 0, 0, 1, 0, 32'h4FC, 0); cycle();
        drive(0, 0, 0, 0, 0, 1, 32'h600, 0); cycle();
        drive(0, 0, 1, 32'h700, 1, 1, 32'h800, 1); cycle();
        check("prio_ret_pc", pc, 32'h500);
        check("prio_no_push", 32'(ras_empty), 1);
        drive(0, 0, 0, 0, 0, 1, 32'h900, 0); cycle();
        drive(1, 0, 0, 0, 0, 1, 32'hA00, 0); cycle();
        check("rst_call_pc", pc, 32'h100);
        check("rst_call_empty", 32'(ras_empty), 1);
        check("rst_flags", 32'({ras_overflow, ras_underflow}), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(4) == 0), ($urandom_range(3) == 0),
                  $urandom, ($urandom_range(7) == 0), ($urandom_range(3) == 0), $urandom,
                  ($urandom_range(4) == 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
